// File: rtl/flit_inject_mux.sv
// N-channel credit-based flit injection mux: per-channel FIFOs, packet-granular round-robin.
// Optional per-channel packet counters are enabled with the INJ_MUX_STATS_EN macro.

module flit_inject_fifo #(
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic [FLIT_SIZE-1:0] wr_data_i,
  input  logic                 rd_i,
  output logic [FLIT_SIZE-1:0] head_o,
  output logic                 empty_o,
  output logic                 full_o
);
  localparam int AW = $clog2(BUF_DEPTH);

  logic [FLIT_SIZE-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(BUF_DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en)      count_d = count_q + (AW+1)'(1);
    else if (!wr_en && rd_en) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

module flit_inject_mux #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 8,
  localparam int GW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_CH-1:0]                src_rx_i,
  output logic [N_CH-1:0]                src_credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0] src_data_i,
  input  logic [N_CH-1:0]                src_eoa_i,
  output logic                           tx_o,
  input  logic                           credit_i,
  output logic [FLIT_SIZE-1:0]           data_o,
  output logic [GW-1:0]                  grant_o,
  output logic                           eoa_o
`ifdef INJ_MUX_STATS_EN
  ,
  output logic [N_CH-1:0][31:0]          pkt_count_o
`endif
);
  typedef enum logic [1:0] {IDLE, HDR, SIZE, PAYLOAD} state_e;

  state_e                         state_q, state_d;
  logic [GW-1:0]                  grant_q, grant_d, last_grant_q, last_grant_d;
  logic [FLIT_SIZE-1:0]           rem_q, rem_d;
  logic                           eoa_q, eoa_d;
  logic [N_CH-1:0]                empty, full, rd;
  logic [N_CH-1:0][FLIT_SIZE-1:0] head;
  logic [GW-1:0]                  sel;
  logic                           sel_found, xfer, pkt_done;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    flit_inject_fifo #(.FLIT_SIZE(FLIT_SIZE), .BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_i      (src_rx_i[g]),
      .wr_data_i (src_data_i[g]),
      .rd_i      (rd[g]),
      .head_o    (head[g]),
      .empty_o   (empty[g]),
      .full_o    (full[g])
    );
  end

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int t;
    t = (int'(base) + k) % N_CH;
    return GW'(t);
  endfunction

  assign src_credit_o = ~full;
  assign tx_o         = (state_q != IDLE) && !empty[grant_q];
  assign xfer         = tx_o && credit_i;
  assign data_o       = head[grant_q];
  assign grant_o      = grant_q;
  assign eoa_o        = eoa_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) rd[i] = xfer && (grant_q == GW'(i));
  end

  // First non-empty channel after the previous winner, wrapping.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!sel_found && !empty[rr_idx(last_grant_q, k)]) begin
        sel_found = 1'b1;
        sel       = rr_idx(last_grant_q, k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rem_d        = rem_q;
    pkt_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = HDR;
        end
      end
      HDR: if (xfer) state_d = SIZE;
      SIZE: begin
        if (xfer) begin
          rem_d = head[grant_q];
          if (head[grant_q] == '0) begin
            state_d  = IDLE;
            pkt_done = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          rem_d = rem_q - FLIT_SIZE'(1);
          if (rem_q == FLIT_SIZE'(1)) begin
            state_d  = IDLE;
            pkt_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    eoa_d = (&src_eoa_i) && (&empty) && (state_q == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_CH - 1);
      rem_q        <= '0;
      eoa_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rem_q        <= rem_d;
      eoa_q        <= eoa_d;
    end
  end

`ifdef INJ_MUX_STATS_EN
  logic [N_CH-1:0][31:0] cnt_q, cnt_d;

  // Saturating per-channel count of completed packets.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pkt_done && (grant_q == GW'(i)) && (cnt_q[i] != 32'hFFFF_FFFF))
        cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pkt_count_o = cnt_q;
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
`endif
endmodule

// File: tb/tb_flit_inject_mux.sv
// Directed bench for flit_inject_mux (N_CH=3); checks output order, timing, credit and eoa.
module tb_flit_inject_mux;
  localparam int N  = 3;
  localparam int FS = 32;
  localparam int BD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      src_rx = '0;
  logic [N-1:0]      credit_o;
  logic [N-1:0][FS-1:0] src_data = '0;
  logic [N-1:0]      src_eoa = '0;
  logic              tx;
  logic              credit_i = 1'b0;
  logic [FS-1:0]     data;
  logic [1:0]        grant;
  logic              eoa;
`ifdef INJ_MUX_STATS_EN
  logic [N-1:0][31:0] pkt_count;
`endif

  flit_inject_mux #(.N_CH(N), .FLIT_SIZE(FS), .BUF_DEPTH(BD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .src_rx_i     (src_rx),
    .src_credit_o (credit_o),
    .src_data_i   (src_data),
    .src_eoa_i    (src_eoa),
    .tx_o         (tx),
    .credit_i     (credit_i),
    .data_o       (data),
    .grant_o      (grant),
    .eoa_o        (eoa)
`ifdef INJ_MUX_STATS_EN
    ,
    .pkt_count_o  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output/input monitor, sampled mid-cycle: entries transfer on the next rising edge.
  logic [FS-1:0] oq_d[$];
  int            oq_g[$];
  int            oq_c[$];
  int            wr0_c[$];
  always @(negedge clk) begin
    if (rst) begin
      oq_d.delete(); oq_g.delete(); oq_c.delete(); wr0_c.delete();
    end else begin
      if (tx && credit_i) begin
        oq_d.push_back(data); oq_g.push_back(int'(grant)); oq_c.push_back(cyc);
      end
      if (src_rx[0] && credit_o[0]) wr0_c.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [FS-1:0] fq0[$], fq1[$], fq2[$];

  task automatic enq(input int ch, input logic [FS-1:0] d);
    case (ch)
      0: fq0.push_back(d);
      1: fq1.push_back(d);
      default: fq2.push_back(d);
    endcase
  endtask

  // Credit-respecting source model: one flit per channel per cycle when credit is high.
  task automatic feed_step();
    src_rx = '0;
    if (rst) begin
      fq0.delete(); fq1.delete(); fq2.delete();
    end else begin
      if (fq0.size() > 0 && credit_o[0]) begin src_rx[0] = 1'b1; src_data[0] = fq0.pop_front(); end
      if (fq1.size() > 0 && credit_o[1]) begin src_rx[1] = 1'b1; src_data[1] = fq1.pop_front(); end
      if (fq2.size() > 0 && credit_o[2]) begin src_rx[2] = 1'b1; src_data[2] = fq2.pop_front(); end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    feed_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (oq_d.size() < n && i < budget) begin tick(); i++; end
    ticks(3);
    chk(tag, 64'(oq_d.size()), 64'(n));
  endtask

  function automatic logic [FS-1:0] od(input int i);
    return (i < oq_d.size()) ? oq_d[i] : 'x;
  endfunction
  function automatic int og(input int i);
    return (i < oq_g.size()) ? oq_g[i] : -1;
  endfunction
  function automatic int oc(input int i);
    return (i < oq_c.size()) ? oq_c[i] : -100;
  endfunction

  logic [FS-1:0] e1 [5]  = '{32'h0101, 32'd3, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
  logic [FS-1:0] e2 [12] = '{32'h0A00, 32'd4, 32'hA1, 32'hA2, 32'hA3, 32'hA4,
                             32'h0B00, 32'd4, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
  logic [FS-1:0] e6 [6]  = '{32'h0D00, 32'd2, 32'hD1, 32'hD2, 32'h0E00, 32'd0};
  int            g6 [6]  = '{0, 0, 0, 0, 2, 2};

  initial begin
    int first_wr, eoa_cyc, i;
    ticks(2);
    chk("rst_tx", 64'(tx), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_eoa", 64'(eoa), 64'd0);
    chk("rst_credit", 64'(credit_o), 64'h7);
    rst = 1'b0;

    // Single packet on ch0.
    credit_i = 1'b1;
    for (int k = 0; k < 5; k++) enq(0, e1[k]);
    wait_out(5, 40, "t1_cnt");
    first_wr = (wr0_c.size() > 0) ? wr0_c[0] : -100;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_data%0d", k), 64'(od(k)), 64'(e1[k]));
      chk($sformatf("t1_grant%0d", k), 64'(og(k)), 64'd0);
    end
    chk("t1_latency", 64'(oc(0)), 64'(first_wr + 2));
    chk("t1_contig", 64'(oc(4)), 64'(oc(0) + 4));
    chk("t1_idle_tx", 64'(tx), 64'd0);

    // Contention: both channels queue a 4-payload packet together.
    reset_dut();
    for (int k = 0; k < 6; k++) begin enq(0, e2[k]); enq(1, e2[k+6]); end
    wait_out(12, 60, "t2_cnt");
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t2_data%0d", k), 64'(od(k)), 64'(e2[k]));
      chk($sformatf("t2_grant%0d", k), 64'(og(k)), (k < 6) ? 64'd0 : 64'd1);
    end
    chk("t2_contig0", 64'(oc(5)), 64'(oc(0) + 5));
    chk("t2_gap", 64'(oc(6)), 64'(oc(5) + 2));

    // Zero-size packets from all channels: strict rotation.
    reset_dut();
    for (int ch = 0; ch < N; ch++)
      for (int p = 0; p < 5; p++) begin
        enq(ch, 32'hC000 + 32'(ch * 16 + p));
        enq(ch, 32'd0);
      end
    wait_out(30, 200, "t3_cnt");
    for (int j = 0; j < 15; j++) begin
      chk($sformatf("t3_grant%0d", j), 64'(og(2*j)), 64'(j % 3));
      chk($sformatf("t3_hdr%0d", j), 64'(od(2*j)), 64'(32'hC000 + 32'((j % 3) * 16 + j / 3)));
      chk($sformatf("t3_size%0d", j), 64'(od(2*j+1)), 64'd0);
    end
`ifdef INJ_MUX_STATS_EN
    for (int ch = 0; ch < N; ch++) chk($sformatf("t3_pktcnt%0d", ch), 64'(pkt_count[ch]), 64'd5);
`endif

    // Backpressure: FIFO fills to depth, then drains intact.
    reset_dut();
    credit_i = 1'b0;
    enq(0, 32'h0F00); enq(0, 32'd8);
    for (int k = 1; k <= 8; k++) enq(0, 32'hF0 + 32'(k));
    ticks(20);
    chk("t4_full_credit", 64'(credit_o[0]), 64'd0);
    chk("t4_accepted", 64'(wr0_c.size()), 64'd8);
    chk("t4_no_out", 64'(oq_d.size()), 64'd0);
    credit_i = 1'b1;
    tick();
    chk("t4_credit_ret", 64'(credit_o[0]), 64'd1);
    wait_out(10, 40, "t4_cnt");
    chk("t4_hdr", 64'(od(0)), 64'h0F00);
    chk("t4_size", 64'(od(1)), 64'd8);
    for (int k = 1; k <= 8; k++) chk($sformatf("t4_pl%0d", k), 64'(od(k+1)), 64'(32'hF0 + 32'(k)));
    chk("t4_wr_total", 64'(wr0_c.size()), 64'd10);

    // End-of-application: held off until ch1's buffered packet drains.
    reset_dut();
    credit_i = 1'b0;
    enq(1, 32'h0E01); enq(1, 32'd0);
    ticks(5);
    src_eoa = 3'b111;
    ticks(4);
    chk("t5_eoa_hold", 64'(eoa), 64'd0);
    credit_i = 1'b1;
    i = 0;
    while (!eoa && i < 30) begin tick(); i++; end
    eoa_cyc = cyc;
    chk("t5_eoa_rise", 64'(eoa), 64'd1);
    chk("t5_out_cnt", 64'(oq_d.size()), 64'd2);
    chk("t5_eoa_lat", 64'(eoa_cyc), 64'(oc(1) + 2));
    src_eoa[0] = 1'b0;
    tick();
    chk("t5_eoa_drop", 64'(eoa), 64'd0);
    src_eoa = '0;

    // Reset mid-packet (ch1, S=5), then grant restarts at ch0.
    enq(1, 32'h0601); enq(1, 32'd5);
    for (int k = 1; k <= 5; k++) enq(1, 32'h60 + 32'(k));
    i = 0;
    while (oq_d.size() < 2 && i < 30) begin tick(); i++; end
    chk("t6_size_sent", 64'(oq_d.size()), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx", 64'(tx), 64'd0);
    chk("t6_rst_credit", 64'(credit_o), 64'h7);
    chk("t6_rst_grant", 64'(grant), 64'd0);
`ifdef INJ_MUX_STATS_EN
    chk("t6_rst_cnt1", 64'(pkt_count[1]), 64'd0);
`endif
    ticks(2);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) enq(0, e6[k]);
    enq(2, e6[4]); enq(2, e6[5]);
    wait_out(6, 40, "t6_cnt");
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t6_data%0d", k), 64'(od(k)), 64'(e6[k]));
      chk($sformatf("t6_grant%0d", k), 64'(og(k)), 64'(g6[k]));
    end
`ifdef INJ_MUX_STATS_EN
    chk("t6_pktcnt0", 64'(pkt_count[0]), 64'd1);
    chk("t6_pktcnt2", 64'(pkt_count[2]), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
